pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 4-register in-order pipeline (IF, ID, EX, MEM). It produces the per-stage stall/flush pair consumed by each stage register. It arbitrates between busy stalls, load-use hazards, taken branches, exceptions and exception-return (ERET), and redirects the fetch PC. It owns the EPC/cause registers and a RUN/EXC/HALT state machine for exception nesting.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_hazard_prio.sv | 66 ++++++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word-address and exception-code widths, ISA
// exception codes, pipeline sequencer states and stage indices.
package cpu_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned ISA_EXP_W   = 3;

  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP      = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT     = 3'd1;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN  = 3'd2;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW    = 3'd3;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN  = 3'd4;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_TRAP        = 3'd5;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_PRV_VIOLATE = 3'd6;

  localparam logic [WORD_ADDR_W-1:0] EXC_VECTOR_DFLT = 30'h0000_0100;

  // Bit positions of each stage within the packed stall/flush vectors.
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned NSTG    = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    EXC  = 2'd1,
    HALT = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_prio.sv
// Combinational priority encoder for the pipeline sequencer: turns the
// current hazard/event inputs and sequencer state into per-stage stall and
// flush controls, the fetch redirect, and which event was accepted.
module pipe_hazard_prio
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = WORD_ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic              rst_i,
  input  pipe_state_t       state_i,
  input  logic              busy_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic              br_i,
  input  logic              hazard_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [NSTG-1:0]   stall_o,
  output logic [NSTG-1:0]   flush_o,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              take_exc_o,
  output logic              take_eret_o
);

  // Highest-priority active event decides the stage controls for this cycle.
  always_comb begin
    stall_o     = '0;
    flush_o     = '0;
    pc_load_o   = 1'b0;
    new_pc_o    = '0;
    take_exc_o  = 1'b0;
    take_eret_o = 1'b0;
    if (rst_i) begin
      flush_o = '1;
    end else if (state_i == HALT) begin
      flush_o   = '1;
      pc_load_o = 1'b1;
      new_pc_o  = EXC_VECTOR;
    end else if (busy_i) begin
      // Memory not ready: freeze everything, defer all redirects.
      stall_o = '1;
    end else if (exc_i) begin
      flush_o    = '1;
      pc_load_o  = 1'b1;
      new_pc_o   = EXC_VECTOR;
      take_exc_o = 1'b1;
    end else if (eret_i && (state_i == EXC)) begin
      flush_o     = '1;
      pc_load_o   = 1'b1;
      new_pc_o    = epc_i;
      take_eret_o = 1'b1;
    end else if (br_i) begin
      // Only the wrong-path fetch sitting in ID needs killing.
      flush_o[STG_ID] = 1'b1;
      pc_load_o       = 1'b1;
      new_pc_o        = br_addr_i;
    end else if (hazard_i) begin
      stall_o[STG_IF] = 1'b1;
      stall_o[STG_ID] = 1'b1;
      flush_o[STG_EX] = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the IF/ID/EX/MEM pipeline: drives per-stage
// stall/flush, redirects fetch, and holds EPC/cause plus the RUN/EXC/HALT
// exception-nesting state.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = WORD_ADDR_W,
  parameter int unsigned       EXP_W      = ISA_EXP_W,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              id_en,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [EXP_W-1:0]  mem_exp_code,
  input  logic              mem_eret,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              pc_load,
  output logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [EXP_W-1:0]  exp_cause,
  output logic [1:0]        state_o
);

  pipe_state_t       state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [EXP_W-1:0]  cause_q, cause_d;

  logic              busy, exc, eret, br;
  logic [NSTG-1:0]   stall, flush;
  logic              take_exc, take_eret;

  assign busy = if_busy | mem_busy;
  assign exc  = mem_en & (mem_exp_code != EXP_W'(ISA_EXP_NO_EXP));
  assign eret = mem_en & mem_eret;
  assign br   = id_en & br_taken;

  pipe_hazard_prio #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_prio (
    .rst_i       (rst),
    .state_i     (state_q),
    .busy_i      (busy),
    .exc_i       (exc),
    .eret_i      (eret),
    .br_i        (br),
    .hazard_i    (ld_hazard),
    .br_addr_i   (br_addr),
    .epc_i       (epc_q),
    .stall_o     (stall),
    .flush_o     (flush),
    .pc_load_o   (pc_load),
    .new_pc_o    (new_pc),
    .take_exc_o  (take_exc),
    .take_eret_o (take_eret)
  );

  assign if_stall  = stall[STG_IF];
  assign id_stall  = stall[STG_ID];
  assign ex_stall  = stall[STG_EX];
  assign mem_stall = stall[STG_MEM];
  assign if_flush  = flush[STG_IF];
  assign id_flush  = flush[STG_ID];
  assign ex_flush  = flush[STG_EX];
  assign mem_flush = flush[STG_MEM];

  assign epc       = epc_q;
  assign exp_cause = cause_q;
  assign state_o   = state_q;

  // Exception nesting: first exception saves EPC/cause, a nested one halts
  // without touching them; ERET in EXC returns to RUN.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    if (take_exc) begin
      if (state_q == RUN) begin
        state_d = EXC;
        epc_d   = mem_pc;
        cause_d = mem_exp_code;
      end else begin
        state_d = HALT;
      end
    end else if (take_eret) begin
      state_d = RUN;
    end
  end

  // Sequencer state and exception registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= '0;
      cause_q <= EXP_W'(ISA_EXP_NO_EXP);
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed walk through reset, hazards,
// branches, exceptions, ERET, busy deferral and nested-exception halt, then
// randomized traffic compared against a rule-level reference model.
module tb_pipe_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_busy, mem_busy, ld_hazard, br_taken, id_en, mem_en, mem_eret;
  logic [29:0] br_addr, mem_pc;
  logic [2:0]  mem_exp_code;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        pc_load;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_cause;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: 0 = running, 1 = in handler, 2 = halted.
  int          m_mode;
  logic [29:0] m_epc;
  logic [2:0]  m_cause;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .ADDR_W     (30),
    .EXP_W      (3),
    .EXC_VECTOR (30'h100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .br_taken     (br_taken),
    .br_addr      (br_addr),
    .id_en        (id_en),
    .mem_en       (mem_en),
    .mem_pc       (mem_pc),
    .mem_exp_code (mem_exp_code),
    .mem_eret     (mem_eret),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem_flush    (mem_flush),
    .pc_load      (pc_load),
    .new_pc       (new_pc),
    .epc          (epc),
    .exp_cause    (exp_cause),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_busy = 0; mem_busy = 0; ld_hazard = 0; br_taken = 0; id_en = 0;
    mem_en = 0; mem_eret = 0; br_addr = '0; mem_pc = '0; mem_exp_code = '0;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance
  // the model with the same inputs the DUT sees on the coming edge.
  task automatic step();
    logic [3:0]  e_stall, e_flush;   // bit order {MEM,EX,ID,IF}
    logic        e_pcl;
    logic [29:0] e_npc;
    logic        busy, exc, eret, br;
    @(negedge clk);
    busy = if_busy | mem_busy;
    exc  = mem_en && (mem_exp_code != 3'd0);
    eret = mem_en && mem_eret;
    br   = id_en && br_taken;
    e_stall = 4'b0000; e_flush = 4'b0000; e_pcl = 0; e_npc = '0;
    if (rst)                    e_flush = 4'b1111;
    else if (m_mode == 2)       begin e_flush = 4'b1111; e_pcl = 1; e_npc = 30'h100; end
    else if (busy)              e_stall = 4'b1111;
    else if (exc)               begin e_flush = 4'b1111; e_pcl = 1; e_npc = 30'h100; end
    else if (eret && m_mode==1) begin e_flush = 4'b1111; e_pcl = 1; e_npc = m_epc; end
    else if (br)                begin e_flush = 4'b0010; e_pcl = 1; e_npc = br_addr; end
    else if (ld_hazard)         begin e_stall = 4'b0011; e_flush = 4'b0100; end
    check("stall", {28'd0, mem_stall, ex_stall, id_stall, if_stall}, {28'd0, e_stall});
    check("flush", {28'd0, mem_flush, ex_flush, id_flush, if_flush}, {28'd0, e_flush});
    check("pc_load", {31'd0, pc_load}, {31'd0, e_pcl});
    check("new_pc", {2'd0, new_pc}, {2'd0, e_npc});
    check("state", {30'd0, state_o}, m_mode);
    check("epc", {2'd0, epc}, {2'd0, m_epc});
    check("cause", {29'd0, exp_cause}, {29'd0, m_cause});
    if (rst) begin
      m_mode = 0; m_epc = '0; m_cause = 3'd0;
    end else if (m_mode != 2 && !busy) begin
      if (exc) begin
        if (m_mode == 0) begin
          m_mode = 1; m_epc = mem_pc; m_cause = mem_exp_code;
        end else begin
          m_mode = 2;
        end
      end else if (eret && m_mode == 1) begin
        m_mode = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    if_busy      = ($urandom_range(0, 11) == 0);
    mem_busy     = ($urandom_range(0, 9) == 0);
    ld_hazard    = ($urandom_range(0, 3) == 0);
    br_taken     = ($urandom_range(0, 3) == 0);
    id_en        = ($urandom_range(0, 3) != 0);
    mem_en       = ($urandom_range(0, 3) != 0);
    mem_eret     = ($urandom_range(0, 4) == 0);
    mem_exp_code = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
    mem_pc       = 30'($urandom);
    br_addr      = 30'($urandom);
  endtask

  initial begin
    int halt_cnt;
    m_mode = 0; m_epc = '0; m_cause = 3'd0;
    clear_inputs();
    rst = 1;
    #1;

    // Reset held for two cycles.
    step();
    step();
    rst = 0;
    #1;
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_epc", {2'd0, epc}, 32'd0);
    check("rst_cause", {29'd0, exp_cause}, {29'd0, ISA_EXP_NO_EXP});
    step();

    // Load-use hazard: stall front, bubble EX.
    ld_hazard = 1;
    #1;
    check("ldh_stall", {30'd0, id_stall, if_stall}, 32'd3);
    check("ldh_exflush", {31'd0, ex_flush}, 32'd1);
    check("ldh_pcload", {31'd0, pc_load}, 32'd0);
    step();
    ld_hazard = 0;
    step();

    // Taken branch beats load-use hazard.
    id_en = 1; br_taken = 1; br_addr = 30'h40; ld_hazard = 1;
    #1;
    check("br_idflush", {31'd0, id_flush}, 32'd1);
    check("br_pcload", {31'd0, pc_load}, 32'd1);
    check("br_newpc", {2'd0, new_pc}, 32'h40);
    check("br_ifstall", {31'd0, if_stall}, 32'd0);
    step();
    clear_inputs();

    // Exception then ERET.
    mem_en = 1; mem_exp_code = ISA_EXP_UNDEF_INSN; mem_pc = 30'h123;
    #1;
    check("exc_flush", {28'd0, mem_flush, ex_flush, id_flush, if_flush}, 32'hf);
    check("exc_newpc", {2'd0, new_pc}, 32'h100);
    step();
    clear_inputs();
    #1;
    check("exc_epc", {2'd0, epc}, 32'h123);
    check("exc_state", {30'd0, state_o}, 32'd1);
    check("exc_cause", {29'd0, exp_cause}, {29'd0, ISA_EXP_UNDEF_INSN});
    mem_en = 1; mem_eret = 1;
    #1;
    check("eret_newpc", {2'd0, new_pc}, 32'h123);
    step();
    clear_inputs();
    #1;
    check("eret_state", {30'd0, state_o}, 32'd0);

    // Exception deferred by mem_busy for three cycles.
    mem_en = 1; mem_exp_code = ISA_EXP_EXT_INT; mem_pc = 30'h55; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_stall", {28'd0, mem_stall, ex_stall, id_stall, if_stall}, 32'hf);
      check("busy_epc", {2'd0, epc}, 32'h123);
      step();
    end
    mem_busy = 0;
    step();
    clear_inputs();
    #1;
    check("busy_epc_taken", {2'd0, epc}, 32'h55);
    check("busy_state", {30'd0, state_o}, 32'd1);

    // Nested exception halts; only reset leaves HALT.
    mem_en = 1; mem_exp_code = ISA_EXP_OVERFLOW; mem_pc = 30'h77;
    step();
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      #1;
      check("halt_state", {30'd0, state_o}, 32'd2);
      check("halt_flush", {28'd0, mem_flush, ex_flush, id_flush, if_flush}, 32'hf);
      check("halt_epc", {2'd0, epc}, 32'h55);
      step();
    end
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
    #1;
    check("halt_rst_state", {30'd0, state_o}, 32'd0);

    // Randomized traffic against the model.
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      halt_cnt = (m_mode == 2) ? halt_cnt + 1 : 0;
      rst = (halt_cnt > 8) || ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
